// File: rtl/regfile_writeback_queue.sv
// -----------------------------------------------------------------------------
// regfile_writeback_queue
//
// Buffered writeback stage in front of the MIPS register file write port.
// Register-write requests from execute/memory are held in an in-order queue of
// DEPTH entries. Each cycle the oldest entry moves into a registered output
// stage that drives the register file write port directly.
//
// Writes to r0 complete the handshake but are dropped, because r0 is hardwired
// to zero and committing such a write has no effect.
//
// Optional feature macro: WBQ_FORWARD_EN
//   defined   : combinational forwarding lookup on read_reg1/read_reg2 across
//               all pending entries plus the output stage. The youngest match
//               wins.
//   undefined : fwd_hit*/fwd_data* are tied to zero and no search logic is
//               built. Decode must then stall while (count != 0 || write_en).
// Queue and issue behaviour is identical in both builds.
// -----------------------------------------------------------------------------
module regfile_writeback_queue #(
  parameter int DEPTH      = 4,   // power of two, 2..16
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  // writeback request side
  input  logic                         wb_valid,
  input  logic [ADDR_WIDTH-1:0]        wb_reg,
  input  logic [DATA_WIDTH-1:0]        wb_data,
  output logic                         wb_ready,
  // register file write port
  output logic                         write_en,
  output logic [ADDR_WIDTH-1:0]        write_reg,
  output logic [DATA_WIDTH-1:0]        write_data,
  // decode forwarding lookup
  input  logic [ADDR_WIDTH-1:0]        read_reg1,
  input  logic [ADDR_WIDTH-1:0]        read_reg2,
  output logic                         fwd_hit1,
  output logic                         fwd_hit2,
  output logic [DATA_WIDTH-1:0]        fwd_data1,
  output logic [DATA_WIDTH-1:0]        fwd_data2,
  // occupancy, excluding the output stage
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t                mem_q [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  write_en_q, write_en_d;
  logic [ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
  logic [DATA_WIDTH-1:0] write_data_q, write_data_d;

  // Handshake and queue events for this cycle
  logic accept;  // handshake completes
  logic store;   // accepted and not addressed to r0
  logic deq;     // head entry moves to the output stage

  // Full/empty come from the count. Pointer equality is ambiguous when the
  // pointers wrap, so it is never used to decide occupancy.
  assign wb_ready = (count_q < FULL_COUNT);
  assign accept   = wb_valid && wb_ready;
  assign store    = accept && (wb_reg != '0);
  assign deq      = (count_q != '0);

  // Next-state for pointers, occupancy and the output stage
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    write_en_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;

    if (deq) begin
      write_en_d   = 1'b1;
      write_reg_d  = mem_q[head_q].rd;
      write_data_d = mem_q[head_q].data;
      head_d       = head_q + PTR_W'(1);  // DEPTH is a power of two, so this wraps
    end

    if (store) begin
      tail_d = tail_q + PTR_W'(1);
    end

    count_d = count_q + CNT_W'(store) - CNT_W'(deq);
  end

  // Control state register with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the values from before the edge.
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      write_en_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      write_en_q   <= write_en_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // Queue storage: written at the tail on every stored request
  always_ff @(posedge clk) begin
    // NOTE: the entry array is deliberately not reset. Validity comes only from
    // head/count, and stale slots are never read as live data.
    if (store) begin
      mem_q[tail_q] <= '{rd: wb_reg, data: wb_data};
    end
  end

  assign write_en   = write_en_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign count      = count_q;

  // ---------------------------------------------------------------------------
  // Forwarding lookup
  // ---------------------------------------------------------------------------
`ifdef WBQ_FORWARD_EN
  logic [ADDR_WIDTH-1:0] lookup_addr [2];
  logic                  lookup_hit  [2];
  logic [DATA_WIDTH-1:0] lookup_data [2];

  assign lookup_addr[0] = read_reg1;
  assign lookup_addr[1] = read_reg2;

  // Search runs from oldest to youngest so that later matches override earlier
  // ones. The output stage is older than every queue entry, and it is searched
  // because its write has not committed yet.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx = head_q;
    for (int p = 0; p < 2; p++) begin
      lookup_hit[p]  = 1'b0;
      lookup_data[p] = '0;
      if (lookup_addr[p] != '0) begin
        if (write_en_q && (write_reg_q == lookup_addr[p])) begin
          lookup_hit[p]  = 1'b1;
          lookup_data[p] = write_data_q;
        end
        for (int k = 0; k < DEPTH; k++) begin
          idx = head_q + PTR_W'(k);
          if ((CNT_W'(k) < count_q) && (mem_q[idx].rd == lookup_addr[p])) begin
            lookup_hit[p]  = 1'b1;
            lookup_data[p] = mem_q[idx].data;
          end
        end
      end
    end
  end

  assign fwd_hit1  = lookup_hit[0];
  assign fwd_hit2  = lookup_hit[1];
  assign fwd_data1 = lookup_data[0];
  assign fwd_data2 = lookup_data[1];
`else
  // No forwarding: decode stalls instead, and the read addresses are unused.
  logic unused_read_regs;
  assign unused_read_regs = ^{read_reg1, read_reg2};

  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// -----------------------------------------------------------------------------
// Self-checking bench for regfile_writeback_queue.
// The reference model is a plain queue of {reg, data} plus one output-stage
// record. Forwarding is modelled as a search from the back of the queue, then
// the output stage. Expectations follow WBQ_FORWARD_EN the same way the design
// does.
// -----------------------------------------------------------------------------
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;
`ifdef WBQ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wb_valid = 1'b0;
  logic [AW-1:0] wb_reg = '0;
  logic [DW-1:0] wb_data = '0;
  logic          wb_ready;
  logic          write_en;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic [AW-1:0] read_reg1 = '0;
  logic [AW-1:0] read_reg2 = '0;
  logic          fwd_hit1, fwd_hit2;
  logic [DW-1:0] fwd_data1, fwd_data2;
  logic [2:0]    count;

  regfile_writeback_queue #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_ready(wb_ready),
    .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mq[$];
  logic          m_we;
  logic [AW-1:0] m_reg;
  logic [DW-1:0] m_data;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_we   = 1'b0;
    m_reg  = '0;
    m_data = '0;
  endtask

  // Youngest pending value for a read address, or a miss.
  task automatic model_fwd(input logic [AW-1:0] rr, output logic hit, output logic [DW-1:0] val);
    hit = 1'b0;
    val = '0;
    if (FWD && rr != 0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!hit && mq[i].rd == rr) begin
          hit = 1'b1;
          val = mq[i].data;
        end
      end
      if (!hit && m_we && m_reg == rr) begin
        hit = 1'b1;
        val = m_data;
      end
    end
  endtask

  // Apply one rising edge to the model using the inputs present at that edge.
  task automatic model_edge();
    bit   acc;
    ent_t e;
    acc = wb_valid && (mq.size() < DEPTH);
    if (mq.size() > 0) begin
      e      = mq.pop_front();
      m_we   = 1'b1;
      m_reg  = e.rd;
      m_data = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (acc && wb_reg != 0) mq.push_back('{rd: wb_reg, data: wb_data});
  endtask

  task automatic compare_all();
    logic          h;
    logic [DW-1:0] v;
    check("wb_ready",   {31'd0, wb_ready}, {31'd0, (mq.size() < DEPTH)});
    check("count",      {29'd0, count},    mq.size());
    check("write_en",   {31'd0, write_en}, {31'd0, m_we});
    check("write_reg",  {27'd0, write_reg}, {27'd0, m_reg});
    check("write_data", write_data, m_data);
    model_fwd(read_reg1, h, v);
    check("fwd_hit1",   {31'd0, fwd_hit1}, {31'd0, h});
    check("fwd_data1",  fwd_data1, v);
    model_fwd(read_reg2, h, v);
    check("fwd_hit2",   {31'd0, fwd_hit2}, {31'd0, h});
    check("fwd_data2",  fwd_data2, v);
  endtask

  // Drive one cycle of inputs, compare mid-cycle, and then advance the model.
  task automatic step(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d,
                      input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    wb_valid  = v;
    wb_reg    = r;
    wb_data   = d;
    read_reg1 = r1;
    read_reg2 = r2;
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_clear();

    // Reset state
    read_reg1 = 5'd3;
    @(negedge clk);
    check("rst_write_en", {31'd0, write_en}, 32'd0);
    check("rst_count",    {29'd0, count},    32'd0);
    check("rst_ready",    {31'd0, wb_ready}, 32'd1);
    check("rst_wreg",     {27'd0, write_reg}, 32'd0);
    check("rst_wdata",    write_data, 32'd0);
    check("rst_fwd_hit1", {31'd0, fwd_hit1}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    idle(2);

    // r1, r2, r3 on consecutive cycles: pin latency and order with literals
    step(1'b1, 5'd1, 32'd5400, '0, '0);
    check("lat_n_we",    {31'd0, write_en}, 32'd0);
    check("lat_n_count", {29'd0, count},    32'd1);
    step(1'b1, 5'd2, 32'd3600, '0, '0);
    check("lat_n1_we",   {31'd0, write_en}, 32'd1);
    check("lat_n1_reg",  {27'd0, write_reg}, 32'd1);
    check("lat_n1_data", write_data, 32'd5400);
    step(1'b1, 5'd3, 32'd1800, '0, '0);
    check("seq2_reg",    {27'd0, write_reg}, 32'd2);
    check("seq2_data",   write_data, 32'd3600);
    step(1'b0, '0, '0, '0, '0);
    check("seq3_reg",    {27'd0, write_reg}, 32'd3);
    check("seq3_data",   write_data, 32'd1800);
    check("seq3_count",  {29'd0, count},    32'd0);
    step(1'b0, '0, '0, '0, '0);
    check("seq_done_we", {31'd0, write_en}, 32'd0);
    check("seq_hold_reg", {27'd0, write_reg}, 32'd3);

    // Sustained accepts: wb_ready is compared every cycle by the model
    for (int i = 0; i < 6; i++) step(1'b1, AW'(4 + i), DW'(100 + i), '0, '0);
    idle(3);

    // r0 writes: accepted but never stored or issued
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5'd0, 32'd7200, 5'd0, 5'd0);
      check("r0_ready", {31'd0, wb_ready}, 32'd1);
      check("r0_count", {29'd0, count},    32'd0);
      check("r0_we",    {31'd0, write_en}, 32'd0);
      check("r0_hit1",  {31'd0, fwd_hit1}, 32'd0);
    end

    // Same register written twice: the younger value is forwarded while pending
    step(1'b1, 5'd3, 32'd1800, 5'd3, 5'd0);
    step(1'b1, 5'd3, 32'd9000, 5'd3, 5'd0);
    check("fwd_young_hit",  {31'd0, fwd_hit1}, {31'd0, FWD});
    check("fwd_young_data", fwd_data1, FWD ? 32'd9000 : 32'd0);
    step(1'b0, '0, '0, 5'd3, 5'd3);
    check("fwd_out_hit",  {31'd0, fwd_hit1}, {31'd0, FWD});
    check("fwd_out_data", fwd_data1, FWD ? 32'd9000 : 32'd0);
    check("dup_reg",      {27'd0, write_reg}, 32'd3);
    check("dup_data",     write_data, 32'd9000);
    step(1'b0, '0, '0, 5'd3, 5'd3);
    check("fwd_gone_hit", {31'd0, fwd_hit1}, 32'd0);

    // Reset asserted mid-drain: takes effect immediately, and nothing issues after
    step(1'b1, 5'd7, 32'd11, 5'd7, 5'd0);
    step(1'b1, 5'd8, 32'd22, 5'd8, 5'd0);
    step(1'b1, 5'd9, 32'd33, 5'd9, 5'd0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_we",    {31'd0, write_en}, 32'd0);
    check("mid_rst_count", {29'd0, count},    32'd0);
    check("mid_rst_ready", {31'd0, wb_ready}, 32'd1);
    check("mid_rst_hit1",  {31'd0, fwd_hit1}, 32'd0);
    model_clear();
    wb_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
    idle(4);

    // Randomized traffic with a small register range, so that forwarding hits are frequent
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), AW'($urandom_range(0, 7)), DW'($urandom()),
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
